// File: rtl/vga_sync_monitor.sv
// Receive-side 640x480 VGA timing monitor: recovers pixel position from incoming
// hsync/vsync, measures line/frame periods and locks once the timing is stable.
module vga_sync_monitor #(
  parameter int H_TOTAL     = 800,
  parameter int V_TOTAL     = 525,
  parameter int HD          = 640,
  parameter int VD          = 480,
  parameter int H_EDGE_LOAD = 656,
  parameter int V_EDGE_LOAD = 513,
  parameter int LOCK_FRAMES = 2,
  parameter int SYNC_POL    = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       p_tick,
  input  logic       hsync_in,
  input  logic       vsync_in,
  output logic [9:0] pixel_x,
  output logic [9:0] pixel_y,
  output logic       video_on,
  output logic [9:0] h_total,
  output logic [9:0] v_total,
  output logic       locked,
  output logic       err
);

  localparam logic       INACT  = (SYNC_POL == 0);
  localparam logic [9:0] SAT    = 10'd1023;
  localparam logic [9:0] HT_M1  = 10'(H_TOTAL - 1);
  localparam logic [9:0] VT     = 10'(V_TOTAL);
  localparam logic [9:0] VT_M1  = 10'(V_TOTAL - 1);
  localparam logic [9:0] HD_L   = 10'(HD);
  localparam logic [9:0] VD_L   = 10'(VD);
  localparam logic [9:0] HLOAD  = 10'(H_EDGE_LOAD);
  localparam logic [9:0] VLOAD  = 10'(V_EDGE_LOAD);
  localparam logic [1:0] LOCK_N = 2'(LOCK_FRAMES);

  typedef enum logic [1:0] {SEARCH, CHECK, LOCKED} state_t;

  state_t     state, state_n;
  logic [1:0] good, good_n;
  logic       locked_n, err_n;
  logic [1:0] hs_sync, vs_sync;
  logic       h_prev, v_prev, h_cur, v_cur;
  logic       h_edge, v_edge, hp_sat, h_bad, frame_ok, line_bad;
  logic [9:0] hp, vp;

  // Synchronizers idle at the pin's deasserted level so reset never fakes an edge
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hs_sync <= {2{INACT}};
      vs_sync <= {2{INACT}};
    end else begin
      hs_sync <= {hs_sync[0], hsync_in};
      vs_sync <= {vs_sync[0], vsync_in};
    end
  end

  assign h_cur    = hs_sync[1] ^ INACT;
  assign v_cur    = vs_sync[1] ^ INACT;
  assign h_edge   = p_tick && h_cur && !h_prev;
  assign v_edge   = p_tick && v_cur && !v_prev;
  assign hp_sat   = p_tick && !h_edge && (hp == SAT);
  assign h_bad    = h_edge && (hp != HT_M1);
  assign frame_ok = !line_bad && !h_bad && !hp_sat && (vp == VT);
  assign video_on = locked && (pixel_x < HD_L) && (pixel_y < VD_L);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      h_prev   <= 1'b0;
      v_prev   <= 1'b0;
      pixel_x  <= '0;
      pixel_y  <= '0;
      hp       <= '0;
      vp       <= '0;
      h_total  <= '0;
      v_total  <= '0;
      line_bad <= 1'b0;
    end else if (p_tick) begin
      h_prev <= h_cur;
      v_prev <= v_cur;

      if (h_edge)                pixel_x <= HLOAD;
      else if (pixel_x == HT_M1) pixel_x <= '0;
      else                       pixel_x <= pixel_x + 10'd1;

      if (v_edge)      pixel_y <= VLOAD;
      else if (h_edge) pixel_y <= (pixel_y == VT_M1) ? '0 : pixel_y + 10'd1;

      if (h_edge) begin
        hp      <= '0;
        h_total <= (hp == SAT) ? SAT : hp + 10'd1;
      end else if (hp != SAT) begin
        hp <= hp + 10'd1;
      end

      // The hsync edge sharing a tick with vsync opens the new frame's line count
      if (v_edge) begin
        v_total <= vp;
        vp      <= h_edge ? 10'd1 : 10'd0;
      end else if (h_edge && vp != SAT) begin
        vp <= vp + 10'd1;
      end

      if (v_edge)               line_bad <= 1'b0;
      else if (h_bad || hp_sat) line_bad <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= SEARCH;
      good   <= '0;
      locked <= 1'b0;
      err    <= 1'b0;
    end else begin
      state  <= state_n;
      good   <= good_n;
      locked <= locked_n;
      err    <= err_n;
    end
  end

  always_comb begin
    state_n  = state;
    good_n   = good;
    locked_n = locked;
    err_n    = 1'b0;
    case (state)
      SEARCH: if (v_edge) begin
        state_n = CHECK;
        good_n  = '0;
      end
      CHECK: begin
        if (hp_sat) begin
          state_n = SEARCH;
          good_n  = '0;
        end else if (v_edge) begin
          if (!frame_ok) begin
            good_n = '0;
          end else if (good + 2'd1 == LOCK_N) begin
            state_n  = LOCKED;
            locked_n = 1'b1;
            good_n   = '0;
          end else begin
            good_n = good + 2'd1;
          end
        end
      end
      LOCKED: if (h_bad || hp_sat || (v_edge && vp != VT)) begin
        err_n    = 1'b1;
        locked_n = 1'b0;
        state_n  = SEARCH;
      end
      default: state_n = SEARCH;
    endcase
  end

endmodule

// File: tb/tb_vga_sync_monitor.sv
// Directed bench: a scaled-down timing generator (40x12) drives an active-high
// monitor and an active-low one; tick indices of every expected event are hand-derived.
module tb_vga_sync_monitor;

  logic       clk = 1'b0, reset = 1'b1, p_tick = 1'b0;
  logic       hs1 = 1'b0, vs1 = 1'b0, hs0 = 1'b1, vs0 = 1'b1;
  logic [9:0] px1, py1, ht1, vt1, px0, py0, ht0, vt0;
  logic       von1, lk1, er1, von0, lk0, er0;

  int n_vec = 0, n_bad = 0;
  int t_next = 0, gx = 0, gy = 0;
  int err_cnt1 = 0, err_cnt0 = 0;
  bit stretch = 0, shorten = 0, kill = 0;

  always #5 clk = ~clk;

  vga_sync_monitor #(.H_TOTAL(40), .V_TOTAL(12), .HD(32), .VD(8), .H_EDGE_LOAD(35),
                     .V_EDGE_LOAD(9), .LOCK_FRAMES(2), .SYNC_POL(1)) u_pos (
    .clk(clk), .reset(reset), .p_tick(p_tick), .hsync_in(hs1), .vsync_in(vs1),
    .pixel_x(px1), .pixel_y(py1), .video_on(von1), .h_total(ht1), .v_total(vt1),
    .locked(lk1), .err(er1));

  vga_sync_monitor #(.H_TOTAL(40), .V_TOTAL(12), .HD(32), .VD(8), .H_EDGE_LOAD(35),
                     .V_EDGE_LOAD(9), .LOCK_FRAMES(2), .SYNC_POL(0)) u_neg (
    .clk(clk), .reset(reset), .p_tick(p_tick), .hsync_in(hs0), .vsync_in(vs0),
    .pixel_x(px0), .pixel_y(py0), .video_on(von0), .h_total(ht0), .v_total(vt0),
    .locked(lk0), .err(er0));

  task automatic chk(input string tag, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // One pixel tick: pins reflect generator position, DUT samples on the p_tick clk
  task automatic do_tick();
    logic h, v;
    @(negedge clk);
    p_tick = 1'b1;
    h = !kill && gx >= 34 && gx <= 37;
    v = !kill && gy >= 9 && gy <= 10;
    hs1 = h; vs1 = v; hs0 = !h; vs0 = !v;
    if (gx == 39) begin
      if (stretch) stretch = 0;
      else begin
        gx = 0;
        if (gy == 11 || (shorten && gy == 10)) begin gy = 0; shorten = 0; end
        else gy++;
      end
    end else gx++;
    @(negedge clk);
    p_tick = 1'b0;
    t_next++;
    if (er1) err_cnt1++;
    if (er0) err_cnt0++;
  endtask

  task automatic run_to(input int n);
    while (t_next <= n) do_tick();
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_px"}, px1, 0);
    chk({tag, "_py"}, py1, 0);
    chk({tag, "_von"}, von1, 0);
    chk({tag, "_ht"}, ht1, 0);
    chk({tag, "_vt"}, vt1, 0);
    chk({tag, "_lk"}, lk1, 0);
    chk({tag, "_err"}, er1, 0);
    chk({tag, "_lk_neg"}, lk0, 0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk_zero("rst_hold");
    reset = 1'b0;
    @(posedge clk); #1;
    chk_zero("rst_rel");

    // Lock acquisition, both polarities
    run_to(35);   chk("ht_1st", ht1, 36);  chk("ht_1st_neg", ht0, 36);
    run_to(75);   chk("ht_2nd", ht1, 40);  chk("ht_2nd_neg", ht0, 40);
    run_to(361);  chk("vt_part", vt1, 9);  chk("vt_part_neg", vt0, 9);
    chk("lk_v1", lk1, 0);
    run_to(841);  chk("vt_full", vt1, 12); chk("vt_full_neg", vt0, 12);
    run_to(1320); chk("lk_pre", lk1, 0);   chk("lk_pre_neg", lk0, 0);
    run_to(1321); chk("lk_v3", lk1, 1);    chk("lk_v3_neg", lk0, 1);
    chk("err_none", err_cnt1, 0);          chk("err_none_neg", err_cnt0, 0);
    run_to(1450); chk("von_in", von1, 1);  chk("px_in", px1, 10); chk("py_in", py1, 0);
    run_to(1473); chk("von_xout", von1, 0); chk("px_xout", px1, 33);

    // One 41-tick line while locked
    run_to(1500); stretch = 1;
    run_to(1555); chk("lk_b4_str", lk1, 1);
    run_to(1556); chk("ht_str", ht1, 41); chk("err_str", er1, 1); chk("lk_str", lk1, 0);
    run_to(1557); chk("err_1clk", er1, 0);
    run_to(2761); chk("relk_pre", lk1, 0);
    run_to(2762); chk("relk", lk1, 1);

    // Syncs held off: hp saturates while pixel_x free-runs
    run_to(2799); kill = 1;
    run_to(3819); chk("lk_b4_sat", lk1, 1);
    run_to(3820); chk("err_sat", er1, 1); chk("lk_sat", lk1, 0); chk("px_sat", px1, 19);
    run_to(3840); chk("px_39", px1, 39);
    run_to(3841); chk("px_wrap", px1, 0);
    run_to(3899); kill = 0;

    // 11-line frame while in CHECK delays lock, no err
    run_to(4682); chk("lk_chk1", lk1, 0); shorten = 1;
    run_to(5122); chk("vt_short", vt1, 11); chk("lk_short", lk1, 0);
    run_to(6081); chk("lk_late_pre", lk1, 0);
    run_to(6082); chk("lk_late", lk1, 1); chk("vt_late", vt1, 12);
    chk("err_cnt_mid", err_cnt1, 2);

    // Asynchronous reset while locked
    run_to(6200); chk("lk_b4_rst", lk1, 1);
    #2 reset = 1'b1;
    #1 chk_zero("rst_mid");
    run_to(6210);
    reset = 1'b0;
    run_to(7041); chk("rlk_pre1", lk1, 0);
    run_to(7521); chk("rlk_pre", lk1, 0); chk("rlk_pre_neg", lk0, 0);
    run_to(7522); chk("rlk", lk1, 1); chk("rlk_neg", lk0, 1);
    chk("vt_end", vt1, 12); chk("ht_end", ht1, 40);
    chk("err_total", err_cnt1, 2); chk("err_total_neg", err_cnt0, 2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/vga_sync_monitor.md
Name: vga_sync_monitor

Overview:
- Receive-side counterpart of the 640x480 VGA timing generator.
- Samples incoming hsync/vsync on the pixel-enable tick and recovers pixel_x/pixel_y and video_on.
- Measures line and frame periods and runs a lock state machine that declares the timing valid or flags errors.
- Used on capture/loopback paths and as a self-checking monitor on the generator's outputs.

Parameters:
- H_TOTAL, 800, expected ticks per line.
- V_TOTAL, 525, expected lines per frame.
- HD, 640, active pixels per line.
- VD, 480, active lines per frame.
- H_EDGE_LOAD, 656, value loaded into the x counter on an hsync leading edge.
- V_EDGE_LOAD, 513, value loaded into the y counter on a vsync leading edge.
- LOCK_FRAMES, 2, consecutive good frames required to lock.
- SYNC_POL, 1, asserted level of hsync_in/vsync_in (1 = active-high).

Ports:
- clk  in  1  system clock (50 MHz).
- reset  in  1  asynchronous, active-high reset.
- p_tick  in  1  pixel enable, one clk wide, 25 MHz rate.
- hsync_in  in  1  incoming horizontal sync, may be asynchronous to clk.
- vsync_in  in  1  incoming vertical sync, may be asynchronous to clk.
- pixel_x  out  10  recovered horizontal position.
- pixel_y  out  10  recovered vertical position.
- video_on  out  1  locked && pixel_x<HD && pixel_y<VD.
- h_total  out  10  last measured line period in ticks.
- v_total  out  10  last measured frame period in lines.
- locked  out  1  timing matches expected values.
- err  out  1  one-clk pulse on a timing violation.

Behaviour:
- Reset is asynchronous, active-high; clock is clk. On reset all outputs are 0, all counters are 0, FSM is in SEARCH, and the synchronizers and edge-history flops clear to the deasserted level.
- Synchronizers: hsync_in and vsync_in each pass through a 2-flop synchronizer clocked every clk. After the synchronizer, XOR with ~SYNC_POL so that internal 1 = asserted.
- Edge detect: prev-sync flops update only when p_tick=1. A leading edge is detected on a tick where current=1 and prev=0. All counters and the FSM advance only when p_tick=1.
- x counter (pixel_x): on an hsync edge, load H_EDGE_LOAD. Otherwise, on a tick with pixel_x==H_TOTAL-1, wrap to 0. Otherwise increment.
- y counter (pixel_y): on a vsync edge, load V_EDGE_LOAD; this has priority over an hsync edge on the same tick. Otherwise, on an hsync edge, increment, wrapping V_TOTAL-1 to 0.
- Line period counter hp (10 bit):
  - Cleared to 0 on an hsync edge; otherwise +1 per tick, saturating at 1023.
  - On each hsync edge, h_total <= hp+1 (saturates at 1023).
- Frame period counter vp (10 bit):
  - Counts hsync edges, saturating at 1023.
  - On a vsync edge: v_total <= vp, then vp <= 1 if an hsync edge occurs on the same tick, else 0.
- line_bad (sticky):
  - Set on any hsync edge where hp+1 != H_TOTAL.
  - Set when hp saturates (no hsync for 1024 ticks).
  - Cleared on a vsync edge.
- frame_ok, evaluated at a vsync edge: !line_bad && vp==V_TOTAL, where the current tick's hsync edge check is included in line_bad.
- Lock FSM (good counter, 2 bit):
  - SEARCH: on a vsync edge -> CHECK, good=0. The first partial frame is ignored.
  - CHECK: on a vsync edge, if frame_ok: good+1; when good+1==LOCK_FRAMES -> LOCKED, locked<=1. If !frame_ok: good=0, stay in CHECK.
  - CHECK: hp saturation -> SEARCH.
  - LOCKED, violations: an hsync edge with hp+1!=H_TOTAL, hp saturating, or a vsync edge with vp!=V_TOTAL.
  - LOCKED, on a violation: err pulses 1 clk on that tick, locked<=0 on the same clk edge, go to SEARCH.
  - err never pulses outside LOCKED.
- Latency: the input pin to internal edge takes 2 clk of synchronizer plus up to 2 clk of tick alignment. H_EDGE_LOAD and V_EDGE_LOAD absorb the pipeline offset.
- Reset mid-operation: immediate return to reset state; locked drops asynchronously.

Test Plan:
- Drive from the team's 640x480 generator, sharing clk/p_tick/reset -> h_total=800 after the 2nd hsync, v_total=525 at the 2nd vsync edge, locked=1 on the 3rd vsync edge tick, err never set.
- Once locked, stretch one line to 801 ticks -> at that hsync edge h_total=801, err=1 for one clk, locked=0. Relock occurs at the 3rd subsequent vsync edge.
- Once locked, hold hsync deasserted -> hp saturates 1024 ticks after the last edge, err pulses, locked=0, pixel_x continues wrapping 0..799.
- SYNC_POL=0 with inverted generator syncs -> identical lock timing and h_total/v_total values as the first scenario.
- Frame of 524 lines while in CHECK -> good resets to 0, no err pulse, lock delayed by one frame.
- Assert reset mid-frame while locked -> all outputs 0 within the same clk. After release, relock occurs on the 3rd vsync edge.
